id_ex_stage: RTL and testbench

//  ID/EX pipeline register with integrated load-use hazard detection for the 5-stage MIPS core.

---
 rtl/id_ex_stage_pkg.sv | 22 ++
 rtl/id_ex_stage_hazard_detect.sv | 32 +++
 rtl/id_ex_stage.sv | 114 +++++++++++
 tb/tb_id_ex_stage.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - shared encodings for the ID/EX stage
package id_ex_stage_pkg;

  // ALU operation codes carried in the ALUOP field
  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_OR  = 4'h3;
  localparam logic [3:0] ALU_SLT = 4'h4;

  // Bubble (NOP) control value: no register write, no memory access
  localparam logic BUBBLE_REG_WRITE  = 1'b0;
  localparam logic BUBBLE_MEM_READ   = 1'b0;
  localparam logic BUBBLE_MEM_WRITE  = 1'b0;
  localparam logic BUBBLE_MEM_TO_REG = 1'b0;
  localparam logic BUBBLE_ALU_SRC    = 1'b0;
  localparam logic [3:0] BUBBLE_ALU_OP = ALU_ADD;

  // Register $0 is hard-wired to zero and never a hazard source
  localparam int ZERO_REG = 0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// rtl/id_ex_stage_hazard_detect.sv - combinational load-use hazard and stall generation
module hazard_detect
  import id_ex_stage_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_dst,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              ex_hold,
  output logic              load_use,
  output logic              stall
);

  logic dst_nonzero;
  logic rs_match;
  logic rt_match;

  // A bubble in ID/EX has ex_valid=0, so a single load yields exactly one bubble
  always_comb begin
    dst_nonzero = (ex_dst != REG_AW'(ZERO_REG));
    rs_match    = id_use_rs && (id_rs == ex_dst);
    rt_match    = id_use_rt && (id_rt == ex_dst);
    load_use    = ex_valid && ex_mem_read && dst_nonzero && (rs_match || rt_match);
    stall       = load_use || ex_hold;
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubble insertion
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               ex_hold,
  input  logic [DATA_W-1:0]  id_pc,
  input  logic [REG_AW-1:0]  id_rs,
  input  logic [REG_AW-1:0]  id_rt,
  input  logic [REG_AW-1:0]  id_dst,
  input  logic               id_use_rs,
  input  logic               id_use_rt,
  input  logic [DATA_W-1:0]  id_data1,
  input  logic [DATA_W-1:0]  id_data2,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic               id_reg_write,
  input  logic               id_mem_read,
  input  logic               id_mem_write,
  input  logic               id_mem_to_reg,
  input  logic               id_alu_src,
  input  logic [ALUOP_W-1:0] id_alu_op,
  output logic [DATA_W-1:0]  ex_pc,
  output logic [REG_AW-1:0]  ex_rs,
  output logic [REG_AW-1:0]  ex_rt,
  output logic [REG_AW-1:0]  ex_dst,
  output logic [DATA_W-1:0]  ex_data1,
  output logic [DATA_W-1:0]  ex_data2,
  output logic [DATA_W-1:0]  ex_imm,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_mem_to_reg,
  output logic               ex_alu_src,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic               ex_valid,
  output logic               stall,
  output logic [CNT_W-1:0]   bubble_cnt
);

  logic load_use;
  logic stall_raw;

  hazard_detect #(.REG_AW(REG_AW)) u_hazard_detect (
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_mem_read),
    .ex_dst      (ex_dst),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .ex_hold     (ex_hold),
    .load_use    (load_use),
    .stall       (stall_raw)
  );

  // Stall is forced low while the core is held in reset
  always_comb begin
    stall = stall_raw && !rst;
  end

  // Pipeline register: flush > hold > load-use bubble > normal load
  always_ff @(posedge clk or posedge rst) begin
    if (rst || (!ex_hold && load_use) || flush) begin
      if (rst || flush || load_use) begin
        ex_pc         <= '0;
        ex_rs         <= '0;
        ex_rt         <= '0;
        ex_dst        <= '0;
        ex_data1      <= '0;
        ex_data2      <= '0;
        ex_imm        <= '0;
        ex_reg_write  <= BUBBLE_REG_WRITE;
        ex_mem_read   <= BUBBLE_MEM_READ;
        ex_mem_write  <= BUBBLE_MEM_WRITE;
        ex_mem_to_reg <= BUBBLE_MEM_TO_REG;
        ex_alu_src    <= BUBBLE_ALU_SRC;
        ex_alu_op     <= ALUOP_W'(BUBBLE_ALU_OP);
        ex_valid      <= 1'b0;
      end
    end else if (!ex_hold) begin
      ex_pc         <= id_pc;
      ex_rs         <= id_rs;
      ex_rt         <= id_rt;
      ex_dst        <= id_dst;
      ex_data1      <= id_data1;
      ex_data2      <= id_data2;
      ex_imm        <= id_imm;
      ex_reg_write  <= id_reg_write;
      ex_mem_read   <= id_mem_read;
      ex_mem_write  <= id_mem_write;
      ex_mem_to_reg <= id_mem_to_reg;
      ex_alu_src    <= id_alu_src;
      ex_alu_op     <= id_alu_op;
      ex_valid      <= 1'b1;
    end
  end

  // Count load-use bubbles actually inserted, saturating at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (!flush && !ex_hold && load_use && (bubble_cnt != {CNT_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;

  localparam int DATA_W  = 32;
  localparam int REG_AW  = 5;
  localparam int ALUOP_W = 4;
  localparam int CNT_W   = 4;

  logic               clk;
  logic               rst;
  logic               flush;
  logic               ex_hold;
  logic [DATA_W-1:0]  id_pc;
  logic [REG_AW-1:0]  id_rs;
  logic [REG_AW-1:0]  id_rt;
  logic [REG_AW-1:0]  id_dst;
  logic               id_use_rs;
  logic               id_use_rt;
  logic [DATA_W-1:0]  id_data1;
  logic [DATA_W-1:0]  id_data2;
  logic [DATA_W-1:0]  id_imm;
  logic               id_reg_write;
  logic               id_mem_read;
  logic               id_mem_write;
  logic               id_mem_to_reg;
  logic               id_alu_src;
  logic [ALUOP_W-1:0] id_alu_op;
  logic [DATA_W-1:0]  ex_pc;
  logic [REG_AW-1:0]  ex_rs;
  logic [REG_AW-1:0]  ex_rt;
  logic [REG_AW-1:0]  ex_dst;
  logic [DATA_W-1:0]  ex_data1;
  logic [DATA_W-1:0]  ex_data2;
  logic [DATA_W-1:0]  ex_imm;
  logic               ex_reg_write;
  logic               ex_mem_read;
  logic               ex_mem_write;
  logic               ex_mem_to_reg;
  logic               ex_alu_src;
  logic [ALUOP_W-1:0] ex_alu_op;
  logic               ex_valid;
  logic               stall;
  logic [CNT_W-1:0]   bubble_cnt;

  int checks;
  int errors;
  int exp_cnt;

  id_ex_stage #(
    .DATA_W(DATA_W), .REG_AW(REG_AW), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .ex_hold(ex_hold),
    .id_pc(id_pc), .id_rs(id_rs), .id_rt(id_rt), .id_dst(id_dst),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_data1(id_data1), .id_data2(id_data2), .id_imm(id_imm),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .id_alu_src(id_alu_src), .id_alu_op(id_alu_op),
    .ex_pc(ex_pc), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst),
    .ex_data1(ex_data1), .ex_data2(ex_data2), .ex_imm(ex_imm),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op),
    .ex_valid(ex_valid), .stall(stall), .bubble_cnt(bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] dst, input logic use_rs, input logic use_rt,
                       input logic mem_read, input logic reg_write);
    id_pc         = pc;
    id_rs         = rs;
    id_rt         = rt;
    id_dst        = dst;
    id_use_rs     = use_rs;
    id_use_rt     = use_rt;
    id_data1      = pc ^ 32'hA5A5_0000;
    id_data2      = pc ^ 32'h0000_5A5A;
    id_imm        = pc + 32'd100;
    id_mem_read   = mem_read;
    id_reg_write  = reg_write;
    id_mem_write  = 1'b0;
    id_mem_to_reg = mem_read;
    id_alu_src    = mem_read;
    id_alu_op     = 4'h1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bubble(input string tag);
    check({tag, "_valid"}, 64'(ex_valid), 64'd0);
    check({tag, "_rw"},    64'(ex_reg_write), 64'd0);
    check({tag, "_mr"},    64'(ex_mem_read), 64'd0);
    check({tag, "_mw"},    64'(ex_mem_write), 64'd0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_pc"},    64'(ex_pc), 64'd0);
    check({tag, "_dst"},   64'(ex_dst), 64'd0);
    check({tag, "_data1"}, 64'(ex_data1), 64'd0);
    check({tag, "_imm"},   64'(ex_imm), 64'd0);
    check({tag, "_aluop"}, 64'(ex_alu_op), 64'd0);
    check({tag, "_cnt"},   64'(bubble_cnt), 64'd0);
    check({tag, "_stall"}, 64'(stall), 64'd0);
    check_bubble(tag);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    exp_cnt = 0;
    rst     = 1'b1;
    flush   = 1'b0;
    ex_hold = 1'b0;
    drive(32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #3;
    check_reset("rst0");
    @(negedge clk);
    rst = 1'b0;

    // lw $t0 followed by add $t1,$t0,$t2
    drive(32'h4, 5'd9, 5'd8, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1);
    #1 check("lw_nostall", 64'(stall), 64'd0);
    step();
    check("lw_valid", 64'(ex_valid), 64'd1);
    check("lw_pc", 64'(ex_pc), 64'h4);
    check("lw_data1", 64'(ex_data1), 64'(32'h4 ^ 32'hA5A5_0000));
    drive(32'h8, 5'd8, 5'd10, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1);
    #1 check("lu_stall", 64'(stall), 64'd1);
    step();
    exp_cnt = 1;
    check_bubble("lu_bub");
    check("lu_cnt", 64'(bubble_cnt), 64'(exp_cnt));
    check("lu_stall_once", 64'(stall), 64'd0);
    step();
    check("add_valid", 64'(ex_valid), 64'd1);
    check("add_rs", 64'(ex_rs), 64'd8);
    check("add_pc", 64'(ex_pc), 64'h8);
    check("add_cnt", 64'(bubble_cnt), 64'(exp_cnt));

    // lw $0 followed by use of $0
    drive(32'hC, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    drive(32'h10, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    #1 check("zero_nostall", 64'(stall), 64'd0);
    step();
    check("zero_valid", 64'(ex_valid), 64'd1);
    // lw $t0 followed by an instruction reading nothing
    drive(32'h14, 5'd1, 5'd8, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    drive(32'h18, 5'd8, 5'd8, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1);
    #1 check("nouse_nostall", 64'(stall), 64'd0);
    step();
    check("nouse_valid", 64'(ex_valid), 64'd1);
    check("nouse_cnt", 64'(bubble_cnt), 64'(exp_cnt));

    // asynchronous reset mid-run while stall is asserted
    ex_hold = 1'b1;
    #1 check("pre_rst_stall", 64'(stall), 64'd1);
    rst = 1'b1;
    #1 check_reset("rst_mid");
    @(negedge clk);
    rst     = 1'b0;
    ex_hold = 1'b0;
    exp_cnt = 0;
    drive(32'h20, 5'd2, 5'd3, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    check("post_rst_valid", 64'(ex_valid), 64'd1);
    check("post_rst_pc", 64'(ex_pc), 64'h20);

    // flush coinciding with load-use
    drive(32'h24, 5'd1, 5'd8, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    drive(32'h28, 5'd8, 5'd2, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1);
    flush = 1'b1;
    #1 check("fl_lu_stall", 64'(stall), 64'd1);
    step();
    flush = 1'b0;
    check_bubble("fl_bub");
    check("fl_cnt", 64'(bubble_cnt), 64'(exp_cnt));
    drive(32'h40, 5'd8, 5'd2, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    check("fl_next_valid", 64'(ex_valid), 64'd1);
    check("fl_next_pc", 64'(ex_pc), 64'h40);

    // ex_hold for three cycles with changing ID inputs
    ex_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(32'h50 + 32'(i * 4), 5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
      #1 check("hold_stall", 64'(stall), 64'd1);
      step();
      check("hold_pc", 64'(ex_pc), 64'h40);
      check("hold_valid", 64'(ex_valid), 64'd1);
    end
    ex_hold = 1'b0;
    drive(32'h60, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    check("hold_rel_pc", 64'(ex_pc), 64'h60);

    // flush together with ex_hold: flush wins
    ex_hold = 1'b1;
    flush   = 1'b1;
    step();
    ex_hold = 1'b0;
    flush   = 1'b0;
    check_bubble("fl_hold");

    // saturating counter with 16 load-use hazards
    for (int i = 0; i < 16; i++) begin
      drive(32'h100 + 32'(i * 8), 5'd1, 5'd8, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1);
      step();
      drive(32'h104 + 32'(i * 8), 5'd2, 5'd8, 5'd9, 1'b0, 1'b1, 1'b0, 1'b1);
      step();
      exp_cnt = (exp_cnt < 15) ? exp_cnt + 1 : 15;
      check("sat_cnt", 64'(bubble_cnt), 64'(exp_cnt));
      check("sat_bub", 64'(ex_valid), 64'd0);
      step();
    end
    check("sat_final", 64'(bubble_cnt), 64'd15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
